// File: rtl/cpu_pkg.sv
// cpu_pkg: bus widths, DMA transfer modes and DMA state encodings shared
// by the CPU-side bus logic and the DMA engine.
package cpu_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   localparam logic [1:0] MODE_FIX   = 2'b00;
   localparam logic [1:0] MODE_INC   = 2'b01;
   localparam logic [1:0] MODE_FETCH = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HALT,
      ST_ALIGN,
      ST_READ,
      ST_WRITE
   } dma_state_t;

   // Mode 11 is reserved and behaves like fetch-only, so only the top bit matters.
   function automatic logic mode_is_fetch(input logic [1:0] m);
      return m[1];
   endfunction

endpackage

// File: rtl/cpu_dma_arbiter.sv
// dma_arbiter: sticky per-channel request bits with fixed priority, lowest
// index wins. A request arriving together with a clear of the same channel
// keeps the channel pending so a re-request is never lost.
module dma_arbiter #(
   parameter int CHANNELS = 2,
   parameter int IDX_W    = 1
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                ce,
   input  logic [CHANNELS-1:0] req,
   input  logic                clear_en,
   input  logic [IDX_W-1:0]    clear_idx,
   output logic [IDX_W-1:0]    grant,
   output logic                any_pending
);

   logic [CHANNELS-1:0] pending;
   logic [CHANNELS-1:0] clear_mask;

   // One-hot mask of the channel being started this cycle.
   always_comb begin
      clear_mask = '0;
      if (clear_en) begin
         clear_mask = CHANNELS'(1) << clear_idx;
      end
   end

   // Pending bits: set by a request, cleared when the channel is started.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
      end else if (ce) begin
         pending <= (pending & ~clear_mask) | req;
      end
   end

   // Fixed-priority pick: scan downwards so the lowest pending index is kept.
   always_comb begin
      grant       = '0;
      any_pending = 1'b0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         if (pending[k]) begin
            grant       = IDX_W'(k);
            any_pending = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cpu_dma.sv
// cpu_dma: multi-channel bus DMA engine. Halts the CPU and moves bytes over
// the shared A/I/D/R/W bus, one ce cycle per bus access.
module cpu_dma
   import cpu_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int LEN_W    = 8,
   parameter int ALIGN    = 1
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      ce,
   input  logic [CHANNELS-1:0]       req,
   input  logic [ADDR_W*CHANNELS-1:0] src,
   input  logic [ADDR_W*CHANNELS-1:0] dst,
   input  logic [LEN_W*CHANNELS-1:0] len,
   input  logic [2*CHANNELS-1:0]     mode,
   output logic [ADDR_W-1:0]         A,
   input  logic [DATA_W-1:0]         I,
   output logic [DATA_W-1:0]         D,
   output logic                      R,
   output logic                      W,
   output logic                      halt,
   output logic                      busy,
   output logic [CHANNELS-1:0]       done,
   output logic [DATA_W-1:0]         fetch_data,
   output logic                      fetch_valid
);

   localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int CNT_W = LEN_W + 1;

   dma_state_t          state, state_n;
   logic                phase;
   logic [ADDR_W-1:0]   cur_src, src_n, cur_dst, dst_n, a_q, a_n;
   logic [CNT_W-1:0]    count, cnt_n;
   logic [1:0]          cur_mode, mode_n;
   logic [IDX_W-1:0]    cur_ch, ch_n, grant;
   logic [DATA_W-1:0]   d_q, d_n, fd_q, fd_n;
   logic                r_q, r_n, w_q, w_n, fv_q, fv_n;
   logic                halt_q, halt_n, busy_q, busy_n;
   logic [CHANNELS-1:0] done_q, done_n;
   logic [LEN_W-1:0]    len_sel;
   logic                any_pending, start, step;

   dma_arbiter #(
      .CHANNELS (CHANNELS),
      .IDX_W    (IDX_W)
   ) u_arbiter (
      .clock       (clock),
      .reset_n     (reset_n),
      .ce          (ce),
      .req         (req),
      .clear_en    (start),
      .clear_idx   (grant),
      .grant       (grant),
      .any_pending (any_pending)
   );

   // Next-state and next-output logic; bus outputs are registered so each
   // value is presented for exactly the ce cycle of its state.
   always_comb begin
      state_n = state;
      src_n   = cur_src;
      dst_n   = cur_dst;
      cnt_n   = count;
      mode_n  = cur_mode;
      ch_n    = cur_ch;
      a_n     = a_q;
      d_n     = d_q;
      r_n     = 1'b0;
      w_n     = 1'b0;
      halt_n  = halt_q;
      busy_n  = busy_q;
      done_n  = '0;
      fd_n    = fd_q;
      fv_n    = 1'b0;
      start   = 1'b0;
      step    = 1'b0;
      len_sel = len[LEN_W*int'(grant) +: LEN_W];

      case (state)
         ST_IDLE:  start = any_pending;
         ST_HALT:  state_n = ((ALIGN != 0) && phase) ? ST_ALIGN : ST_READ;
         ST_ALIGN: state_n = ST_READ;
         ST_READ: begin
            if (mode_is_fetch(cur_mode)) begin
               fd_n = I;
               fv_n = 1'b1;
               step = 1'b1;
            end else begin
               state_n = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (cur_mode == MODE_INC) begin
               dst_n = cur_dst + 1'b1;
            end
            step = 1'b1;
         end
         default: state_n = ST_IDLE;
      endcase

      if (step) begin
         src_n = cur_src + 1'b1;
         cnt_n = count - 1'b1;
         if (count == CNT_W'(1)) begin
            done_n  = CHANNELS'(1) << cur_ch;
            busy_n  = 1'b0;
            halt_n  = 1'b0;
            state_n = ST_IDLE;
            start   = any_pending;
         end else begin
            state_n = ST_READ;
         end
      end

      if (start) begin
         ch_n    = grant;
         src_n   = src[ADDR_W*int'(grant) +: ADDR_W];
         dst_n   = dst[ADDR_W*int'(grant) +: ADDR_W];
         mode_n  = mode[2*int'(grant) +: 2];
         cnt_n   = (len_sel == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_sel};
         busy_n  = 1'b1;
         halt_n  = 1'b1;
         state_n = ST_HALT;
      end

      if (state_n == ST_READ) begin
         a_n = src_n;
         r_n = 1'b1;
      end else if (state_n == ST_WRITE) begin
         a_n = cur_dst;
         d_n = I;
         w_n = 1'b1;
      end
   end

   // State and output registers; nothing moves while ce is low.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         phase    <= 1'b0;
         cur_src  <= '0;
         cur_dst  <= '0;
         count    <= '0;
         cur_mode <= '0;
         cur_ch   <= '0;
         a_q      <= '0;
         d_q      <= '0;
         r_q      <= 1'b0;
         w_q      <= 1'b0;
         halt_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= '0;
         fd_q     <= '0;
         fv_q     <= 1'b0;
      end else if (ce) begin
         state    <= state_n;
         phase    <= ~phase;
         cur_src  <= src_n;
         cur_dst  <= dst_n;
         count    <= cnt_n;
         cur_mode <= mode_n;
         cur_ch   <= ch_n;
         a_q      <= a_n;
         d_q      <= d_n;
         r_q      <= r_n;
         w_q      <= w_n;
         halt_q   <= halt_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
         fd_q     <= fd_n;
         fv_q     <= fv_n;
      end
   end

   assign A           = a_q;
   assign D           = d_q;
   assign R           = r_q & ce;
   assign W           = w_q & ce;
   assign halt        = halt_q;
   assign busy        = busy_q;
   assign done        = done_q & {CHANNELS{ce}};
   assign fetch_data  = fd_q;
   assign fetch_valid = fv_q & ce;

endmodule

// File: tb/tb_cpu_dma.sv
// tb_cpu_dma: directed bench for cpu_dma with a pattern memory on the bus
// and a monitor that logs every strobe seen in a ce cycle.
module tb_cpu_dma;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        ce;
   logic [1:0]  req;
   logic [31:0] src, dst;
   logic [15:0] len;
   logic [3:0]  mode;
   logic [15:0] A;
   logic [7:0]  I, D, fetch_data;
   logic        R, W, halt, busy, fetch_valid;
   logic [1:0]  done;

   int n_cmp = 0;
   int n_fail = 0;

   logic [15:0] rd_q[$];
   logic [15:0] wr_q[$];
   logic [7:0]  wd_q[$];
   logic [1:0]  done_q[$];
   logic [7:0]  fv_q[$];
   int          halt_cnt, idle_halt, halt_runs;
   logic        halt_prev, tb_phase;

   cpu_dma #(.CHANNELS(2), .LEN_W(8), .ALIGN(1)) dut (
      .clock(clock), .reset_n(reset_n), .ce(ce), .req(req), .src(src), .dst(dst),
      .len(len), .mode(mode), .A(A), .I(I), .D(D), .R(R), .W(W), .halt(halt),
      .busy(busy), .done(done), .fetch_data(fetch_data), .fetch_valid(fetch_valid)
   );

   always #20 clock = ~clock;

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   assign I = mem_byte(A);

   // Reference bus phase: toggles once per ce cycle from reset.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) tb_phase <= 1'b0;
      else if (ce) tb_phase <= ~tb_phase;
   end

   // Bus monitor, sampled mid-cycle.
   always @(negedge clock) begin
      if (reset_n && ce) begin
         if (R) rd_q.push_back(A);
         if (W) begin
            wr_q.push_back(A);
            wd_q.push_back(D);
         end
         if (halt) halt_cnt++;
         if (halt && !R && !W) idle_halt++;
         if (halt && !halt_prev) halt_runs++;
         halt_prev = halt;
         if (done != 2'b00) done_q.push_back(done);
         if (fetch_valid) fv_q.push_back(fetch_data);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clearLogs();
      rd_q.delete(); wr_q.delete(); wd_q.delete(); done_q.delete(); fv_q.delete();
      halt_cnt = 0; idle_halt = 0; halt_runs = 0; halt_prev = 1'b0;
   endtask

   task automatic setChannel(input int ch, input logic [15:0] s, input logic [15:0] d,
                             input logic [7:0] l, input logic [1:0] m);
      src[ch*16 +: 16] = s;
      dst[ch*16 +: 16] = d;
      len[ch*8 +: 8]   = l;
      mode[ch*2 +: 2]  = m;
   endtask

   // Pulse req for one ce cycle, optionally on a chosen bus phase (-1 = any).
   task automatic applyStimulus(input logic [1:0] mask, input int want_phase);
      int guard = 0;
      @(posedge clock); #1;
      while (want_phase >= 0 && tb_phase != want_phase[0] && guard < 4) begin
         @(posedge clock); #1;
         guard++;
      end
      req = mask;
      @(posedge clock); #1;
      req = 2'b00;
   endtask

   task automatic waitDone(input string tag, input int n, input int budget);
      int cyc = 0;
      while (done_q.size() < n && cyc < budget) begin
         @(negedge clock);
         cyc++;
      end
      checkOutput({tag, "_done_cnt"}, done_q.size(), n);
      repeat (3) @(negedge clock);
   endtask

   // Check n logged transfers starting at log index off.
   task automatic checkSeg(input string tag, input int off, input logic [15:0] rbase,
                           input logic [15:0] wbase, input bit winc, input int n);
      logic [15:0] ra, wa;
      for (int i = 0; i < n; i++) begin
         ra = rbase + 16'(i);
         wa = winc ? wbase + 16'(i) : wbase;
         if (off + i < rd_q.size())
            checkOutput($sformatf("%s_rd%0d", tag, i), rd_q[off+i], ra);
         if (off + i < wr_q.size()) begin
            checkOutput($sformatf("%s_wa%0d", tag, i), wr_q[off+i], wa);
            checkOutput($sformatf("%s_wd%0d", tag, i), wd_q[off+i], mem_byte(ra));
         end
      end
   endtask

   initial begin
      #(40 * 20000);
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int g;
      reset_n = 1'b0; ce = 1'b1; req = 2'b00;
      src = '0; dst = '0; len = '0; mode = '0;
      clearLogs();
      repeat (3) @(posedge clock);
      #5;
      checkOutput("rst_A", A, 0);
      checkOutput("rst_D", D, 0);
      checkOutput("rst_RW", {R, W}, 0);
      checkOutput("rst_halt_busy", {halt, busy}, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_fetch", {fetch_valid, fetch_data}, 0);
      reset_n = 1'b1;

      // OAM-style copy of a full page to a fixed register, even phase.
      $display("[TB] OAM copy");
      clearLogs();
      setChannel(0, 16'h0200, 16'h2004, 8'd0, 2'b00);
      applyStimulus(2'b01, 0);
      waitDone("oam", 1, 700);
      checkOutput("oam_rd_cnt", rd_q.size(), 256);
      checkOutput("oam_wr_cnt", wr_q.size(), 256);
      checkSeg("oam", 0, 16'h0200, 16'h2004, 1'b0, 256);
      checkOutput("oam_halt", halt_cnt, 513);
      checkOutput("oam_idle_halt", idle_halt, 1);
      checkOutput("oam_done", done_q[0], 2'b01);

      // Same request on an odd phase picks up one align cycle.
      $display("[TB] alignment");
      clearLogs();
      applyStimulus(2'b01, 1);
      waitDone("align", 1, 700);
      checkOutput("align_rd_cnt", rd_q.size(), 256);
      checkSeg("align", 0, 16'h0200, 16'h2004, 1'b0, 4);
      checkOutput("align_halt", halt_cnt, 514);
      checkOutput("align_idle_halt", idle_halt, 2);

      // Increment mode with source wrap-around.
      $display("[TB] increment with wrap");
      clearLogs();
      setChannel(0, 16'hFFFE, 16'h0600, 8'd4, 2'b01);
      applyStimulus(2'b01, 0);
      waitDone("inc", 1, 50);
      checkOutput("inc_rd_cnt", rd_q.size(), 4);
      checkOutput("inc_wr_cnt", wr_q.size(), 4);
      checkSeg("inc", 0, 16'hFFFE, 16'h0600, 1'b1, 4);
      checkOutput("inc_halt", halt_cnt, 9);

      // Fetch-only mode on channel 1, then reserved mode 11.
      $display("[TB] fetch mode");
      clearLogs();
      setChannel(1, 16'hC000, 16'h1234, 8'd3, 2'b10);
      applyStimulus(2'b10, 0);
      waitDone("fetch", 1, 50);
      checkOutput("fetch_wr_cnt", wr_q.size(), 0);
      checkOutput("fetch_fv_cnt", fv_q.size(), 3);
      for (int i = 0; i < 3 && i < fv_q.size(); i++)
         checkOutput($sformatf("fetch_byte%0d", i), fv_q[i], mem_byte(16'hC000 + 16'(i)));
      checkSeg("fetch", 0, 16'hC000, 16'h0000, 1'b0, 3);
      checkOutput("fetch_halt", halt_cnt, 4);
      checkOutput("fetch_done", done_q[0], 2'b10);

      clearLogs();
      setChannel(1, 16'hC100, 16'h1234, 8'd2, 2'b11);
      applyStimulus(2'b10, 0);
      waitDone("m11", 1, 50);
      checkOutput("m11_wr_cnt", wr_q.size(), 0);
      checkOutput("m11_fv_cnt", fv_q.size(), 2);
      for (int i = 0; i < 2 && i < fv_q.size(); i++)
         checkOutput($sformatf("m11_byte%0d", i), fv_q[i], mem_byte(16'hC100 + 16'(i)));
      checkOutput("m11_halt", halt_cnt, 3);

      // Higher priority request during a transfer waits, then follows at once.
      $display("[TB] priority and pending");
      clearLogs();
      setChannel(1, 16'h1000, 16'h3000, 8'd4, 2'b01);
      setChannel(0, 16'h2000, 16'h4000, 8'd2, 2'b00);
      applyStimulus(2'b10, -1);
      repeat (3) @(posedge clock);
      applyStimulus(2'b01, -1);
      waitDone("prio", 2, 80);
      checkOutput("prio_rd_cnt", rd_q.size(), 6);
      checkSeg("prio_ch1", 0, 16'h1000, 16'h3000, 1'b1, 4);
      checkSeg("prio_ch0", 4, 16'h2000, 16'h4000, 1'b0, 2);
      checkOutput("prio_done0", done_q[0], 2'b10);
      checkOutput("prio_done1", done_q[1], 2'b01);
      checkOutput("prio_halt_runs", halt_runs, 1);

      clearLogs();
      applyStimulus(2'b11, -1);
      waitDone("simul", 2, 80);
      checkOutput("simul_rd_cnt", rd_q.size(), 6);
      checkSeg("simul_ch0", 0, 16'h2000, 16'h4000, 1'b0, 2);
      checkSeg("simul_ch1", 2, 16'h1000, 16'h3000, 1'b1, 4);
      checkOutput("simul_done0", done_q[0], 2'b01);
      checkOutput("simul_done1", done_q[1], 2'b10);
      checkOutput("simul_halt_runs", halt_runs, 1);

      // Freeze with ce=0 in the middle of a write and resume.
      $display("[TB] ce freeze");
      clearLogs();
      setChannel(0, 16'h0500, 16'h0700, 8'd6, 2'b01);
      applyStimulus(2'b01, 0);
      g = 0;
      while (!(R && A == 16'h0501) && g < 50) begin
         @(negedge clock);
         g++;
      end
      checkOutput("ce_reach_A", A, 16'h0501);
      @(posedge clock); #1;
      ce = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         checkOutput($sformatf("ce_hold_A%0d", i), A, 16'h0701);
         checkOutput($sformatf("ce_hold_RW%0d", i), {R, W}, 0);
      end
      @(posedge clock); #1;
      ce = 1'b1;
      waitDone("ce", 1, 50);
      checkOutput("ce_rd_cnt", rd_q.size(), 6);
      checkOutput("ce_wr_cnt", wr_q.size(), 6);
      checkSeg("ce", 0, 16'h0500, 16'h0700, 1'b1, 6);
      checkOutput("ce_halt", halt_cnt, 13);

      // Reset mid-transfer with another channel pending.
      $display("[TB] reset mid-transfer");
      clearLogs();
      setChannel(0, 16'h0800, 16'h0900, 8'd8, 2'b00);
      setChannel(1, 16'h0A00, 16'h0B00, 8'd2, 2'b00);
      applyStimulus(2'b01, -1);
      applyStimulus(2'b10, -1);
      g = 0;
      while (rd_q.size() < 3 && g < 50) begin
         @(negedge clock);
         g++;
      end
      #7;
      reset_n = 1'b0;
      #1;
      checkOutput("rmid_A", A, 0);
      checkOutput("rmid_D", D, 0);
      checkOutput("rmid_halt_busy", {halt, busy}, 0);
      checkOutput("rmid_strobes", {R, W, done, fetch_valid}, 0);
      clearLogs();
      @(posedge clock); #5;
      reset_n = 1'b1;
      repeat (20) @(negedge clock);
      checkOutput("rmid_no_done", done_q.size(), 0);
      checkOutput("rmid_no_reads", rd_q.size(), 0);
      checkOutput("rmid_idle", {halt, busy}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
